// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared types, constants and header check for the instruction loader
package inst_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // A header is a word count; zero words or more words than the memory holds are rejected.
  function automatic logic hdr_ok(input logic [7:0] n, input int addr_w);
    return (n != 8'd0) && (32'(n) <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - byte stream in and instruction-memory write bundle
interface inst_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Host / memory side.
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_loader_word_packer.sv
// rtl/inst_loader_word_packer.sv - 4-lane byte register with running XOR checksum
module inst_loader_word_packer
  import inst_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        load,
  input  logic [1:0]                  lane,
  input  logic [7:0]                  byte_in,
  output logic [8*BYTES_PER_WORD-1:0] word,
  output logic [7:0]                  csum
);

  // Drop each accepted byte into its lane and fold it into the checksum; clr starts a new load.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      csum <= 8'd0;
    end else if (clr) begin
      word <= '0;
      csum <= 8'd0;
    end else if (load) begin
      word[{lane, 3'b000} +: 8] <= byte_in;
      csum                      <= csum ^ byte_in;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - boot loader: header, packed words to instruction memory, checksum, core reset release
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  inst_loader_if.slave bus,
  input  logic         reload,
  output logic         cpu_rst,
  output logic         done,
  output logic         err
);

  state_t            state, state_nxt;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] last_idx;
  logic              pk_clr;
  logic              pk_load;
  logic [DATA_W-1:0] pk_word;
  logic [7:0]        pk_csum;

  inst_loader_word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (pk_clr),
    .load    (pk_load),
    .lane    (byte_idx),
    .byte_in (bus.in_data),
    .word    (pk_word),
    .csum    (pk_csum)
  );

  // The write address is the word counter itself; data comes straight from the packer register.
  assign bus.mem_addr  = word_idx;
  assign bus.mem_wdata = pk_word;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= HDR;
    else     state <= state_nxt;
  end

  // Next state and Moore outputs; in_valid only steers transitions and packer strobes.
  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    cpu_rst      = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    pk_clr       = 1'b0;
    pk_load      = 1'b0;
    case (state)
      HDR: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (hdr_ok(bus.in_data, ADDR_W)) begin
            pk_clr    = 1'b1;
            state_nxt = DATA;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      DATA: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          pk_load = 1'b1;
          if (byte_idx == 2'd3) state_nxt = WRITE;
        end
      end
      WRITE: begin
        bus.mem_we = 1'b1;
        state_nxt  = (word_idx == last_idx) ? CSUM : DATA;
      end
      CSUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = (bus.in_data == pk_csum) ? DONE : ERR;
      end
      DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (reload) state_nxt = HDR;
      end
      ERR: begin
        err = 1'b1;
        if (reload) state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  // Byte lane and word counters; last_idx holds N-1 so N=2**ADDR_W still fits the address width.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx <= 2'd0;
      word_idx <= '0;
      last_idx <= '0;
    end else begin
      case (state)
        HDR: if (bus.in_valid) begin
          byte_idx <= 2'd0;
          word_idx <= '0;
          last_idx <= ADDR_W'(bus.in_data - 8'd1);
        end
        DATA: if (bus.in_valid && byte_idx != 2'd3) byte_idx <= byte_idx + 2'd1;
        WRITE: if (word_idx != last_idx) begin
          word_idx <= word_idx + 1'b1;
          byte_idx <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed self-checking bench for inst_loader
module tb_inst_loader;

  logic clk = 1'b0;
  logic rst;
  logic reload;
  logic cpu_rst;
  logic done;
  logic err;

  always #5 clk = ~clk;

  inst_loader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  inst_loader #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .reload  (reload),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [4:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] exp_w[32];

  // Log every cycle with mem_we high; a stretched strobe shows up as an extra entry.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Offer one byte from a negedge, hold it until accepted, return on the following negedge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check_eq("send_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check_eq({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    check_eq({tag, "_mem_addr"}, {27'd0, bus.mem_addr}, 32'd0);
    check_eq({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check_eq({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2_bytes [8];
    logic [7:0] ck;
    logic [7:0] ib;
    t2_bytes = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};

    rst = 1'b1;
    reload = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rst");

    // One word, checksum 0x16, in_valid back to back.
    clear_log();
    send_byte(8'h01);
    send_word(32'h00000513);
    send_byte(8'h16);
    check_eq("t1_done", {31'd0, done}, 32'd1);
    check_eq("t1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check_eq("t1_err", {31'd0, err}, 32'd0);
    check_eq("t1_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("t1_nwr", wa_q.size(), 32'd1);
    if (wa_q.size() > 0) begin
      check_eq("t1_addr", {27'd0, wa_q[0]}, 32'd0);
      check_eq("t1_data", wd_q[0], 32'h00000513);
    end
    do_reload();
    check_eq("rl1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check_eq("rl1_done", {31'd0, done}, 32'd0);
    check_eq("rl1_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Two words with random gaps; checksum C3 ^ 02 = C1.
    clear_log();
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(t2_bytes[i]);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    send_byte(8'hC1);
    check_eq("t2_done", {31'd0, done}, 32'd1);
    check_eq("t2_nwr", wa_q.size(), 32'd2);
    if (wa_q.size() > 1) begin
      check_eq("t2_addr0", {27'd0, wa_q[0]}, 32'd0);
      check_eq("t2_data0", wd_q[0], 32'h00500093);
      check_eq("t2_addr1", {27'd0, wa_q[1]}, 32'd1);
      check_eq("t2_data1", wd_q[1], 32'h00100113);
    end
    do_reload();

    // Bad checksum, then bytes offered while in ERR must not be consumed or written.
    clear_log();
    send_byte(8'h01);
    send_word(32'h00000513);
    send_byte(8'h17);
    check_eq("t3_err", {31'd0, err}, 32'd1);
    check_eq("t3_done", {31'd0, done}, 32'd0);
    check_eq("t3_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check_eq("t3_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h13;
    repeat (6) @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("t3_nwr", wa_q.size(), 32'd1);
    check_eq("t3_err_hold", {31'd0, err}, 32'd1);
    do_reload();

    // Header out of range at both ends.
    clear_log();
    send_byte(8'h00);
    check_eq("t4_err_zero", {31'd0, err}, 32'd1);
    do_reload();
    check_eq("t4_err_clr", {31'd0, err}, 32'd0);
    send_byte(8'h21);
    check_eq("t4_err_33", {31'd0, err}, 32'd1);
    check_eq("t4_nwr", wa_q.size(), 32'd0);
    do_reload();

    // Reset mid-load, then a fresh load from address 0.
    clear_log();
    send_byte(8'h02);
    send_word(32'h44332211);
    send_byte(8'h55);
    send_byte(8'h66);
    check_eq("t5_nwr_part", wa_q.size(), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("t5_rst");
    clear_log();
    send_byte(8'h01);
    send_word(32'hDDCCBBAA);
    send_byte(8'h00);
    check_eq("t5_done", {31'd0, done}, 32'd1);
    check_eq("t5_nwr", wa_q.size(), 32'd1);
    if (wa_q.size() > 0) begin
      check_eq("t5_addr", {27'd0, wa_q[0]}, 32'd0);
      check_eq("t5_data", wd_q[0], 32'hDDCCBBAA);
    end
    do_reload();

    // Full 32-word load.
    clear_log();
    ck = 8'h00;
    for (int i = 0; i < 32; i++) begin
      ib = 8'(i);
      exp_w[i] = {ib ^ 8'hA5, 8'h3C, ib, ~ib};
      ck = ck ^ (ib ^ 8'hA5) ^ 8'h3C ^ ib ^ ~ib;
    end
    send_byte(8'h20);
    for (int i = 0; i < 32; i++) send_word(exp_w[i]);
    send_byte(ck);
    check_eq("t6_done", {31'd0, done}, 32'd1);
    check_eq("t6_nwr", wa_q.size(), 32'd32);
    for (int i = 0; i < 32; i++) begin
      if (i < wa_q.size()) begin
        check_eq($sformatf("t6_addr%0d", i), {27'd0, wa_q[i]}, 32'(i));
        check_eq($sformatf("t6_data%0d", i), wd_q[i], exp_w[i]);
      end
    end
    do_reload();
    check_eq("t6_rl_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check_eq("t6_rl_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Second load after reload; checksum 12^34^56^78 = 08.
    clear_log();
    send_byte(8'h01);
    send_word(32'h12345678);
    send_byte(8'h08);
    check_eq("t7_done", {31'd0, done}, 32'd1);
    check_eq("t7_nwr", wa_q.size(), 32'd1);
    if (wa_q.size() > 0) begin
      check_eq("t7_addr", {27'd0, wa_q[0]}, 32'd0);
      check_eq("t7_data", wd_q[0], 32'h12345678);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
